systolic_ctrl: RTL and testbench

Sequencer for the TPU's N×N weight-stationary systolic array. For one matrix operation it loads weights, streams activation rows, and writes result rows. It drives the weight, activation and result buffer ports, plus the array's weight-shift and activation-valid strobes. It sits between the HPS-facing command registers (start, row count, base addresses) and the array/buffer datapath inside `tpus_system`.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/valid_delay_line.sv | 25 ++
 rtl/systolic_ctrl.sv | 160 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FEED,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam int DEF_N   = 8;
    localparam int DEF_AW  = 8;
    localparam int DEF_LAT = 2 * DEF_N;

endpackage

// File: rtl/valid_delay_line.sv
// Shift-register delay for a single valid bit, with an all-stages-clear flag.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic bit_i,
    output logic bit_o,
    output logic empty_o
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= DEPTH'({sr_q, bit_i});
        end
    end

    assign bit_o   = sr_q[DEPTH-1];
    assign empty_o = ~|sr_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: load weights, stream activations, write results.
// Optional cycle counter output perf_cycles enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int AW  = DEF_AW,
    parameter int LAT = DEF_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] m_rows,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] r_base,
    output logic          busy,
    output logic          done,
    output logic          w_rd_en,
    output logic [AW-1:0] w_rd_addr,
    output logic          w_load,
    output logic          a_rd_en,
    output logic [AW-1:0] a_rd_addr,
    output logic          a_valid,
    output logic          r_wr_en,
    output logic [AW-1:0] r_wr_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    ctrl_state_t   state_q;
    logic [AW-1:0] cnt_q, res_cnt_q, m_q, wb_q, ab_q, rb_q;
    logic          busy_q, done_q, w_rd_en_q, w_load_q, a_rd_en_q, a_valid_q, r_wr_en_q;
    logic [AW-1:0] w_rd_addr_q, a_rd_addr_q, r_wr_addr_q;
    logic          dl_out, dl_empty;

    // The final r_wr_en register adds the last cycle of the LAT-cycle delay.
    valid_delay_line #(.DEPTH(LAT - 1)) u_dly (
        .clk_i   (clk),
        .reset_i (reset),
        .bit_i   (a_valid_q),
        .bit_o   (dl_out),
        .empty_o (dl_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_cnt_q   <= '0;
            m_q         <= '0;
            wb_q        <= '0;
            ab_q        <= '0;
            rb_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            w_load_q    <= 1'b0;
            a_rd_en_q   <= 1'b0;
            a_rd_addr_q <= '0;
            a_valid_q   <= 1'b0;
            r_wr_en_q   <= 1'b0;
            r_wr_addr_q <= '0;
        end else begin
            w_load_q  <= w_rd_en_q;
            a_valid_q <= a_rd_en_q;
            r_wr_en_q <= dl_out;
            done_q    <= 1'b0;
            if (dl_out) begin
                r_wr_addr_q <= rb_q + res_cnt_q;
                res_cnt_q   <= res_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q         <= m_rows;
                        wb_q        <= w_base;
                        ab_q        <= a_base;
                        rb_q        <= r_base;
                        cnt_q       <= '0;
                        res_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                        w_rd_en_q   <= 1'b1;
                        w_rd_addr_q <= w_base;
                        state_q     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (cnt_q == AW'(N - 1)) begin
                        w_rd_en_q <= 1'b0;
                        cnt_q     <= '0;
                        if (m_q != '0) begin
                            a_rd_en_q   <= 1'b1;
                            a_rd_addr_q <= ab_q;
                            state_q     <= FEED;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        w_rd_addr_q <= wb_q + cnt_q + 1'b1;
                    end
                end
                FEED: begin
                    if (cnt_q == m_q - 1'b1) begin
                        a_rd_en_q <= 1'b0;
                        state_q   <= DRAIN;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        a_rd_addr_q <= ab_q + cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Exit once nothing feeds the output registers, so done lands right after the last strobe.
                    if (!a_valid_q && dl_empty) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign w_rd_en   = w_rd_en_q;
    assign w_rd_addr = w_rd_addr_q;
    assign w_load    = w_load_q;
    assign a_rd_en   = a_rd_en_q;
    assign a_rd_addr = a_rd_addr_q;
    assign a_valid   = a_valid_q;
    assign r_wr_en   = r_wr_en_q;
    assign r_wr_addr = r_wr_addr_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_q <= '0;
        end else if (busy_q && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized self-checking bench for systolic_ctrl against a cycle-table reference model.
module tb_systolic_ctrl;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] m_rows = '0, w_base = '0, a_base = '0, r_base = '0;
    logic          busy, done, w_rd_en, w_load, a_rd_en, a_valid, r_wr_en;
    logic [AW-1:0] w_rd_addr, a_rd_addr, r_wr_addr;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    systolic_ctrl #(.N(N), .AW(AW), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .m_rows    (m_rows),
        .w_base    (w_base),
        .a_base    (a_base),
        .r_base    (r_base),
        .busy      (busy),
        .done      (done),
        .w_rd_en   (w_rd_en),
        .w_rd_addr (w_rd_addr),
        .w_load    (w_load),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .a_valid   (a_valid),
        .r_wr_en   (r_wr_en),
        .r_wr_addr (r_wr_addr)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] wb;
        logic [7:0] ab;
        logic [7:0] rb;
    } cmd_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       w_rd_en;
        logic [7:0] w_rd_addr;
        logic       w_load;
        logic       a_rd_en;
        logic [7:0] a_rd_addr;
        logic       a_valid;
        logic       r_wr_en;
        logic [7:0] r_wr_addr;
    } obs_t;

    function automatic int done_cycle(input cmd_t c);
        return (c.m == 8'd0) ? N + 2 : N + int'(c.m) + LAT + 2;
    endfunction

    // Expected outputs in cycle t after the start-sampling edge (t = 0).
    function automatic obs_t model(input int t, input cmd_t c);
        obs_t e = '0;
        int   m = int'(c.m);
        int   d = done_cycle(c);
        e.busy = (t >= 1 && t <= d);
        e.done = (t == d);
        if (t >= 1 && t <= N) begin
            e.w_rd_en   = 1'b1;
            e.w_rd_addr = c.wb + 8'(t - 1);
        end
        e.w_load = (t >= 2 && t <= N + 1);
        if (t >= N + 1 && t <= N + m) begin
            e.a_rd_en   = 1'b1;
            e.a_rd_addr = c.ab + 8'(t - N - 1);
        end
        e.a_valid = (t >= N + 2 && t <= N + m + 1);
        if (t >= N + 2 + LAT && t <= N + m + 1 + LAT) begin
            e.r_wr_en   = 1'b1;
            e.r_wr_addr = c.rb + 8'(t - N - 2 - LAT);
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy      = busy;
        o.done      = done;
        o.w_rd_en   = w_rd_en;
        o.w_rd_addr = w_rd_en ? w_rd_addr : 8'h00;
        o.w_load    = w_load;
        o.a_rd_en   = a_rd_en;
        o.a_rd_addr = a_rd_en ? a_rd_addr : 8'h00;
        o.a_valid   = a_valid;
        o.r_wr_en   = r_wr_en;
        o.r_wr_addr = r_wr_en ? r_wr_addr : 8'h00;
        return o;
    endfunction

    task automatic scramble_inputs();
        m_rows = 8'($urandom);
        w_base = 8'($urandom);
        a_base = 8'($urandom);
        r_base = 8'($urandom);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 with start released.
    task automatic issue(input cmd_t c);
        m_rows = c.m;
        w_base = c.wb;
        a_base = c.ab;
        r_base = c.rb;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = sample();
            n_cmp++;
            if (o !== obs_t'(0)) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%h want=0", i, o);
            end
            @(negedge clk);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_perf got=%0d want=0", perf_cycles);
        end
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        o = sample();
        n_cmp++;
        if (o !== obs_t'(0)) begin
            n_err++;
            $display("FAIL idle_after_reset got=%h want=0", o);
        end
    endtask

    task automatic test_basic();
        cmd_t c = '{m: 8'd3, wb: 8'h10, ab: 8'h20, rb: 8'h30};
        int   d = done_cycle(c);
        obs_t o, e;
        issue(c);
        for (int t = 1; t <= d + 2; t++) begin
            o = sample();
            e = model(t, c);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL basic t=%0d got=%h want=%h", t, o, e);
            end
            @(negedge clk);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'd17) begin
            n_err++;
            $display("FAIL basic_perf got=%0d want=17", perf_cycles);
        end
`endif
    endtask

    task automatic test_m_zero();
        cmd_t c = '{m: 8'd0, wb: 8'($urandom), ab: 8'($urandom), rb: 8'($urandom)};
        int   d = done_cycle(c);
        obs_t o, e;
        issue(c);
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL perf_clear got=%0d want=0", perf_cycles);
        end
`endif
        for (int t = 1; t <= d + 3; t++) begin
            o = sample();
            e = model(t, c);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL m_zero t=%0d got=%h want=%h", t, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        cmd_t c = '{m: 8'd4, wb: 8'hFD, ab: 8'hFE, rb: 8'hFF};
        int   d = done_cycle(c);
        obs_t o, e;
        issue(c);
        for (int t = 1; t <= d + 2; t++) begin
            o = sample();
            e = model(t, c);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL wrap t=%0d got=%h want=%h", t, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        cmd_t c  = '{m: 8'd3, wb: 8'h40, ab: 8'h50, rb: 8'h60};
        cmd_t c2 = '{m: 8'd2, wb: 8'($urandom), ab: 8'($urandom), rb: 8'($urandom)};
        int   d  = done_cycle(c);
        int   d2 = done_cycle(c2);
        obs_t o, e;
        issue(c);
        for (int t = 1; t <= d + 1; t++) begin
            o = sample();
            e = model(t, c);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL start_ignored t=%0d got=%h want=%h", t, o, e);
            end
            if (t == d) begin
                m_rows = c2.m;
                w_base = c2.wb;
                a_base = c2.ab;
                r_base = c2.rb;
            end
            start = (t == N + 2) || (t >= d);
            @(negedge clk);
        end
        start = 1'b0;
        scramble_inputs();
        for (int t = 1; t <= d2 + 2; t++) begin
            o = sample();
            e = model(t, c2);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL back_to_back t=%0d got=%h want=%h", t, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        cmd_t c;
        int   d;
        obs_t o, e;
        for (int n = 0; n < 6; n++) begin
            c.m  = 8'($urandom_range(0, 6));
            c.wb = 8'($urandom);
            c.ab = (n % 2 == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            c.rb = 8'($urandom_range(250, 255));
            d = done_cycle(c);
            issue(c);
            for (int t = 1; t <= d + 1 + int'($urandom_range(0, 2)); t++) begin
                o = sample();
                e = model(t, c);
                n_cmp++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL random n=%0d m=%0d t=%0d got=%h want=%h", n, c.m, t, o, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        cmd_t c = '{m: 8'd3, wb: 8'h10, ab: 8'h20, rb: 8'h30};
        obs_t o, e;
        issue(c);
        for (int t = 1; t <= 8; t++) begin
            o = sample();
            e = model(t, c);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid_pre t=%0d got=%h want=%h", t, o, e);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        o = sample();
        n_cmp++;
        if (o !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_mid_async got=%h want=0", o);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            @(negedge clk);
            o = sample();
            n_cmp++;
            if (o !== obs_t'(0)) begin
                n_err++;
                $display("FAIL reset_mid_quiet cyc=%0d got=%h want=0", i, o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_m_zero();
        test_wrap();
        test_start_ignored();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
